// File: rtl/pdm_pkg.sv
// pdm_pkg: shared widths, defaults and PCM conversion for the PDM decimator
package pdm_pkg;

    localparam int DEF_WIN_LEN = 1134;
    localparam int DEF_OUT_W   = 16;

    function automatic int cnt_w(input int win_len);
        return $clog2(win_len);
    endfunction

    function automatic int acc_w(input int win_len);
        return $clog2(win_len + 1);
    endfunction

    // Ones-count to PCM word, saturated to the out_w range; caller truncates to out_w bits
    function automatic logic [63:0] to_pcm(input int count, input int win_len, input int out_w, input bit signed_out);
        longint v, hi, lo;
        v  = signed_out ? (longint'(count) <<< 1) - longint'(win_len) : longint'(count);
        hi = signed_out ? (longint'(1) <<< (out_w - 1)) - longint'(1) : (longint'(1) <<< out_w) - longint'(1);
        lo = signed_out ? -(longint'(1) <<< (out_w - 1)) : longint'(0);
        v  = v > hi ? hi : (v < lo ? lo : v);
        return v;
    endfunction

endpackage

// File: rtl/pdm_decim_mc_accum.sv
// pdm_ch_accum: one channel's window ones-counter and PCM conversion
module pdm_ch_accum
    import pdm_pkg::*;
#(
    parameter int WIN_LEN    = DEF_WIN_LEN,
    parameter int OUT_W      = DEF_OUT_W,
    parameter bit SIGNED_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sample,
    input  logic             close,
    output logic [OUT_W-1:0] result
);

    localparam int ACC_W = acc_w(WIN_LEN);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    // sum includes the current sample so the closing cycle is counted
    assign sum    = acc + ACC_W'(sample);
    assign result = OUT_W'(to_pcm(int'(sum), WIN_LEN, OUT_W, SIGNED_OUT));

    // Accumulate on enabled cycles; restart from zero as the window closes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (en)
            acc <= close ? '0 : sum;
    end

endmodule

// File: rtl/pdm_decim_mc.sv
// pdm_decim_mc: multi-channel PDM-to-PCM box-filter decimator with valid/ready output
module pdm_decim_mc
    import pdm_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int WIN_LEN    = DEF_WIN_LEN,
    parameter int OUT_W      = DEF_OUT_W,
    parameter bit SIGNED_OUT = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       pdm_in,
    output logic [NUM_CH*OUT_W-1:0] pcm_out,
    output logic                    pcm_vld,
    input  logic                    pcm_rdy,
    output logic                    overrun,
    input  logic                    ovr_clr
);

    localparam int CNT_W = cnt_w(WIN_LEN);
    localparam int ACC_W = acc_w(WIN_LEN);

    if (SIGNED_OUT ? (OUT_W < ACC_W + 1) : (OUT_W < ACC_W)) begin : g_width_chk
        $error("pdm_decim_mc: OUT_W too narrow for WIN_LEN, results will saturate");
    end

    logic [CNT_W-1:0]        timer;
    logic                    close;
    logic [NUM_CH*OUT_W-1:0] res;

    assign close = en && (timer == CNT_W'(WIN_LEN - 1));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pdm_ch_accum #(
            .WIN_LEN   (WIN_LEN),
            .OUT_W     (OUT_W),
            .SIGNED_OUT(SIGNED_OUT)
        ) u_accum (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .sample(pdm_in[i]),
            .close (close),
            .result(res[i*OUT_W +: OUT_W])
        );
    end

    // Shared window timer, advancing only on enabled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timer <= '0;
        else if (en)
            timer <= close ? '0 : timer + CNT_W'(1);
    end

    // Output register, handshake and sticky overrun; a close always loads and wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_out <= '0;
            pcm_vld <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (close)
                pcm_out <= res;
            pcm_vld <= close ? 1'b1 : (pcm_vld && pcm_rdy ? 1'b0 : pcm_vld);
            overrun <= (close && pcm_vld && !pcm_rdy) ? 1'b1 : (ovr_clr ? 1'b0 : overrun);
        end
    end

endmodule

// File: tb/tb_pdm_decim_mc.sv
// tb_pdm_decim_mc: directed checks of the PDM decimator in unsigned, signed and default builds
module tb_pdm_decim_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en, rdy, clr;
    logic [1:0]  pdm;
    logic [31:0] pcm;
    logic        vld, ovr;

    logic        en_s, rdy_s;
    logic [1:0]  pdm_s;
    logic [31:0] pcm_s;
    logic        vld_s, ovr_s;

    logic        en_d, rdy_d;
    logic [1:0]  pdm_d;
    logic [31:0] pcm_d;
    logic        vld_d, ovr_d;

    int tests = 0;
    int fails = 0;

    pdm_decim_mc #(.NUM_CH(2), .WIN_LEN(8), .OUT_W(16), .SIGNED_OUT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pdm_in(pdm), .pcm_out(pcm),
        .pcm_vld(vld), .pcm_rdy(rdy), .overrun(ovr), .ovr_clr(clr)
    );

    pdm_decim_mc #(.NUM_CH(2), .WIN_LEN(8), .OUT_W(16), .SIGNED_OUT(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en_s), .pdm_in(pdm_s), .pcm_out(pcm_s),
        .pcm_vld(vld_s), .pcm_rdy(rdy_s), .overrun(ovr_s), .ovr_clr(1'b0)
    );

    pdm_decim_mc dut_d (
        .clk(clk), .rst_n(rst_n), .en(en_d), .pdm_in(pdm_d), .pcm_out(pcm_d),
        .pcm_vld(vld_d), .pcm_rdy(rdy_d), .overrun(ovr_d), .ovr_clr(1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic e, input logic [1:0] p, input logic r, input logic c);
        en = e; pdm = p; rdy = r; clr = c;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        en = 0; rdy = 0; clr = 0; pdm = 0;
        en_s = 0; rdy_s = 0; pdm_s = 0;
        en_d = 0; rdy_d = 0; pdm_d = 0;
        step(); step();
        chk("rst_pcm", pcm, 0);
        chk("rst_vld", vld, 0);
        chk("rst_ovr", ovr, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cyc(1, 2'b11, 1, 0);
            if (i == 6) chk("ones_early_vld", vld, 0);
        end
        chk("ones_vld", vld, 1);
        chk("ones_pcm", pcm, {16'd8, 16'd8});
        for (int i = 0; i < 8; i++) begin
            cyc(1, 2'b00, 1, 0);
            if (i == 0) chk("consume_vld", vld, 0);
        end
        chk("zeros_vld", vld, 1);
        chk("zeros_pcm", pcm, 0);

        cyc(0, 2'b00, 1, 0);
        chk("idle_consume_vld", vld, 0);
        for (int i = 0; i < 8; i++) cyc(1, i < 3 ? 2'b11 : 2'b00, 0, 0);
        chk("winA_pcm", pcm, {16'd3, 16'd3});
        chk("winA_vld", vld, 1);
        chk("winA_ovr", ovr, 0);
        for (int i = 0; i < 8; i++) cyc(1, i < 5 ? 2'b11 : 2'b00, 0, 0);
        chk("winB_pcm", pcm, {16'd5, 16'd5});
        chk("winB_vld", vld, 1);
        chk("winB_ovr", ovr, 1);
        cyc(0, 2'b00, 0, 1);
        chk("clr_ovr", ovr, 0);
        chk("clr_vld", vld, 1);
        chk("clr_pcm_hold", pcm, {16'd5, 16'd5});
        for (int i = 0; i < 8; i++) cyc(1, 2'b11, i == 7, 0);
        chk("winC_ovr", ovr, 0);
        chk("winC_vld", vld, 1);
        chk("winC_pcm", pcm, {16'd8, 16'd8});

        cyc(0, 2'b11, 1, 0);
        chk("pre_en_vld", vld, 0);
        for (int k = 0; k < 8; k++) begin
            cyc(1, 2'b11, 0, 0);
            chk("entog_vld", vld, k == 7);
            cyc(0, 2'b11, 0, 0);
            cyc(0, 2'b11, 0, 0);
        end
        chk("entog_pcm", pcm, {16'd8, 16'd8});
        chk("entog_ovr", ovr, 0);

        for (int i = 0; i < 5; i++) cyc(1, 2'b11, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pcm", pcm, 0);
        chk("midrst_vld", vld, 0);
        chk("midrst_ovr", ovr, 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1, i < 2 ? 2'b11 : 2'b00, 0, 0);
            if (i == 6) chk("postrst_early_vld", vld, 0);
        end
        chk("postrst_vld", vld, 1);
        chk("postrst_pcm", pcm, {16'd2, 16'd2});

        en_s = 1; rdy_s = 1; pdm_s = 2'b01;
        for (int i = 0; i < 8; i++) step();
        chk("sgn_vld", vld_s, 1);
        chk("sgn_pcm", pcm_s, {16'hFFF8, 16'h0008});
        for (int i = 0; i < 8; i++) begin
            pdm_s = (i % 2 == 0) ? 2'b11 : 2'b00;
            step();
        end
        chk("sgn_alt_vld", vld_s, 1);
        chk("sgn_alt_pcm", pcm_s, 0);
        en_s = 0;

        en_d = 1; rdy_d = 1; pdm_d = 2'b11;
        repeat (1133) step();
        chk("def_early_vld", vld_d, 0);
        step();
        chk("def_vld", vld_d, 1);
        chk("def_pcm", pcm_d, {16'h046E, 16'h046E});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
